// File: rtl/sdf_twiddle_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// sdf_twiddle_multiplier_pkg
// Shared definitions for the SDF twiddle multiplier:
//   - default twiddle width / fraction constants
//   - multiply/bypass mode encoding
//   - round-half-up + saturate helper used on the final complex sums
// -----------------------------------------------------------------------------
package sdf_twiddle_multiplier_pkg;

    localparam int TW_W_DEF    = 13;
    localparam int TW_FRAC_DEF = 11;

    // Wide enough for any full-precision sum this block can produce.
    localparam int ACC_W = 64;

    typedef enum logic {
        MODE_BYPASS = 1'b0,
        MODE_MULT   = 1'b1
    } mode_e;

    typedef struct packed {
        logic                    sat;
        logic signed [ACC_W-1:0] val;
    } rs_t;

    // Add half an LSB, drop 'frac' fraction bits (floor), then clamp to a
    // signed out_w-bit range. val is already inside that range on return.
    function automatic rs_t round_sat(input logic signed [ACC_W-1:0] sum,
                                      input int frac,
                                      input int out_w);
        logic signed [ACC_W-1:0] r;
        logic signed [ACC_W-1:0] lim_hi;
        logic signed [ACC_W-1:0] lim_lo;
        rs_t                     res;
        r      = (sum + (64'sd1 <<< (frac - 1))) >>> frac;
        lim_hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lim_lo = -(64'sd1 <<< (out_w - 1));
        if (r > lim_hi) begin
            res.sat = 1'b1;
            res.val = lim_hi;
        end else if (r < lim_lo) begin
            res.sat = 1'b1;
            res.val = lim_lo;
        end else begin
            res.sat = 1'b0;
            res.val = r;
        end
        return res;
    endfunction

endpackage

// File: rtl/sdf_twiddle_multiplier_if.sv
// -----------------------------------------------------------------------------
// sdf_twiddle_multiplier_if
// Streaming sample bus into and out of the twiddle multiplier.
//   in_valid/in_sop/in_real/in_imag     : upstream sample (no backpressure)
//   out_valid/out_sop/out_mode/out_sat  : downstream qualifiers
//   out_real/out_imag                   : downstream sample
// Modports: master = sample producer / result consumer, slave = multiplier.
// -----------------------------------------------------------------------------
interface sdf_twiddle_multiplier_if #(
    parameter int DATA_W = 15,
    parameter int OUT_W  = 16
);
    logic                     in_valid;
    logic                     in_sop;
    logic signed [DATA_W-1:0] in_real;
    logic signed [DATA_W-1:0] in_imag;
    logic                     out_valid;
    logic                     out_sop;
    logic                     out_mode;
    logic                     out_sat;
    logic signed [OUT_W-1:0]  out_real;
    logic signed [OUT_W-1:0]  out_imag;

    modport master (
        output in_valid, in_sop, in_real, in_imag,
        input  out_valid, out_sop, out_mode, out_sat, out_real, out_imag
    );

    modport slave (
        input  in_valid, in_sop, in_real, in_imag,
        output out_valid, out_sop, out_mode, out_sat, out_real, out_imag
    );
endinterface

// File: rtl/sdf_twiddle_multiplier_rom.sv
// -----------------------------------------------------------------------------
// sdf_twiddle_multiplier_rom
// Combinational twiddle lookup for one SDF stage, block length M.
//   i_p    : position inside the block (cnt mod M)
//   o_wr   : Re(W_M^p), TW_FRAC fraction bits
//   o_wi   : Im(W_M^p) = -sin(2*pi*p/M)
//   o_mode : MODE_MULT for the first half of the block, MODE_BYPASS otherwise
// The table is computed at elaboration from $cos/$sin.
// -----------------------------------------------------------------------------
module sdf_twiddle_multiplier_rom
    import sdf_twiddle_multiplier_pkg::*;
#(
    parameter int N_LOG2  = 3,
    parameter int STAGE   = 1,
    parameter int TW_W    = TW_W_DEF,
    parameter int TW_FRAC = TW_FRAC_DEF
) (
    input  logic [N_LOG2-STAGE-1:0] i_p,
    output logic signed [TW_W-1:0]  o_wr,
    output logic signed [TW_W-1:0]  o_wi,
    output mode_e                   o_mode
);
    localparam int  P_W = N_LOG2 - STAGE;
    localparam int  M   = 1 << P_W;
    localparam real PI  = 3.14159265358979323846;

    // Quantise with round half away from zero.
    function automatic logic signed [TW_W-1:0] tw_quant(input int p, input bit imag);
        real ang;
        real x;
        real s;
        ang = 2.0 * PI * $itor(p) / $itor(M);
        x   = imag ? -$sin(ang) : $cos(ang);
        s   = x * $itor(1 << TW_FRAC);
        if (s >= 0.0)
            return TW_W'($rtoi(s + 0.5));
        else
            return TW_W'(-$rtoi(-s + 0.5));
    endfunction

    logic signed [TW_W-1:0] w_tab_re [M];
    logic signed [TW_W-1:0] w_tab_im [M];

    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_tab
            localparam logic signed [TW_W-1:0] LP_RE = tw_quant(gi, 1'b0);
            localparam logic signed [TW_W-1:0] LP_IM = tw_quant(gi, 1'b1);
            if (gi < M / 2) begin : g_mult
                assign w_tab_re[gi] = LP_RE;
                assign w_tab_im[gi] = LP_IM;
            end else begin : g_byp
                assign w_tab_re[gi] = '0;
                assign w_tab_im[gi] = '0;
            end
        end
    endgenerate

    assign o_wr   = w_tab_re[i_p];
    assign o_wi   = w_tab_im[i_p];
    // p < M/2 exactly when the top bit of p is clear.
    assign o_mode = i_p[P_W-1] ? MODE_BYPASS : MODE_MULT;

endmodule

// File: rtl/sdf_twiddle_multiplier.sv
// -----------------------------------------------------------------------------
// sdf_twiddle_multiplier
// Pipelined twiddle multiplier for one radix-2 SDF FFT stage.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   io_bus : sample bus (slave side), see sdf_twiddle_multiplier_if
// Three register stages for every sample: S1 input + twiddle, S2 the four
// partial products, S3 sum/round/saturate (or sign-extended bypass).
// A frame counter, resynchronised by in_sop, selects the twiddle.
// -----------------------------------------------------------------------------
module sdf_twiddle_multiplier
    import sdf_twiddle_multiplier_pkg::*;
#(
    parameter int N_LOG2  = 3,
    parameter int STAGE   = 1,
    parameter int DATA_W  = 15,
    parameter int TW_W    = TW_W_DEF,
    parameter int TW_FRAC = TW_FRAC_DEF,
    parameter int OUT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sdf_twiddle_multiplier_if.slave  io_bus
);
    localparam int P_W    = N_LOG2 - STAGE;
    localparam int PROD_W = DATA_W + TW_W;
    localparam int SUM_W  = PROD_W + 1;

    // ---------------- counter / twiddle select ----------------
    logic [N_LOG2-1:0]      r_cnt;
    logic [N_LOG2-1:0]      w_cnt_eff;
    logic signed [TW_W-1:0] w_rom_wr;
    logic signed [TW_W-1:0] w_rom_wi;
    mode_e                  w_rom_mode;

    // A start-of-frame sample always uses position 0, wherever the counter was.
    assign w_cnt_eff = io_bus.in_sop ? '0 : r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (io_bus.in_valid)
            r_cnt <= w_cnt_eff + 1'b1;
    end

    sdf_twiddle_multiplier_rom #(
        .N_LOG2 (N_LOG2),
        .STAGE  (STAGE),
        .TW_W   (TW_W),
        .TW_FRAC(TW_FRAC)
    ) u_rom (
        .i_p   (w_cnt_eff[P_W-1:0]),
        .o_wr  (w_rom_wr),
        .o_wi  (w_rom_wi),
        .o_mode(w_rom_mode)
    );

    // ---------------- S1: input and twiddle ----------------
    logic                     r_s1_valid, r_s1_sop;
    mode_e                    r_s1_mode;
    logic signed [DATA_W-1:0] r_s1_ar, r_s1_ai;
    logic signed [TW_W-1:0]   r_s1_wr, r_s1_wi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sop   <= 1'b0;
            r_s1_mode  <= MODE_BYPASS;
            r_s1_ar    <= '0;
            r_s1_ai    <= '0;
            r_s1_wr    <= '0;
            r_s1_wi    <= '0;
        end else begin
            r_s1_valid <= io_bus.in_valid;
            r_s1_sop   <= io_bus.in_valid & io_bus.in_sop;
            r_s1_mode  <= w_rom_mode;
            r_s1_ar    <= io_bus.in_real;
            r_s1_ai    <= io_bus.in_imag;
            r_s1_wr    <= w_rom_wr;
            r_s1_wi    <= w_rom_wi;
        end
    end

    // ---------------- S2: partial products ----------------
    logic                     r_s2_valid, r_s2_sop;
    mode_e                    r_s2_mode;
    logic signed [DATA_W-1:0] r_s2_ar, r_s2_ai;
    logic signed [PROD_W-1:0] r_s2_p_rr, r_s2_p_ii, r_s2_p_ri, r_s2_p_ir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sop   <= 1'b0;
            r_s2_mode  <= MODE_BYPASS;
            r_s2_ar    <= '0;
            r_s2_ai    <= '0;
            r_s2_p_rr  <= '0;
            r_s2_p_ii  <= '0;
            r_s2_p_ri  <= '0;
            r_s2_p_ir  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_sop   <= r_s1_sop;
            r_s2_mode  <= r_s1_mode;
            r_s2_ar    <= r_s1_ar;
            r_s2_ai    <= r_s1_ai;
            r_s2_p_rr  <= PROD_W'(r_s1_ar) * PROD_W'(r_s1_wr);
            r_s2_p_ii  <= PROD_W'(r_s1_ai) * PROD_W'(r_s1_wi);
            r_s2_p_ri  <= PROD_W'(r_s1_ar) * PROD_W'(r_s1_wi);
            r_s2_p_ir  <= PROD_W'(r_s1_ai) * PROD_W'(r_s1_wr);
        end
    end

    // ---------------- S3: sum, round, saturate ----------------
    logic signed [SUM_W-1:0] w_sum_re, w_sum_im;
    rs_t                     w_rs_re, w_rs_im;

    always_comb begin
        w_sum_re = SUM_W'(r_s2_p_rr) - SUM_W'(r_s2_p_ii);
        w_sum_im = SUM_W'(r_s2_p_ri) + SUM_W'(r_s2_p_ir);
        w_rs_re  = round_sat(ACC_W'(w_sum_re), TW_FRAC, OUT_W);
        w_rs_im  = round_sat(ACC_W'(w_sum_im), TW_FRAC, OUT_W);
    end

    logic                    r_out_valid, r_out_sop, r_out_sat;
    mode_e                   r_out_mode;
    logic signed [OUT_W-1:0] r_out_re, r_out_im;

    // Data and mode hold through gaps; the per-sample flags drop to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_sat   <= 1'b0;
            r_out_mode  <= MODE_BYPASS;
            r_out_re    <= '0;
            r_out_im    <= '0;
        end else begin
            r_out_valid <= r_s2_valid;
            r_out_sop   <= r_s2_valid & r_s2_sop;
            r_out_sat   <= r_s2_valid & (r_s2_mode == MODE_MULT) & (w_rs_re.sat | w_rs_im.sat);
            if (r_s2_valid) begin
                r_out_mode <= r_s2_mode;
                if (r_s2_mode == MODE_MULT) begin
                    r_out_re <= OUT_W'(w_rs_re.val);
                    r_out_im <= OUT_W'(w_rs_im.val);
                end else begin
                    r_out_re <= OUT_W'(r_s2_ar);
                    r_out_im <= OUT_W'(r_s2_ai);
                end
            end
        end
    end

    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_sop   = r_out_sop;
    assign io_bus.out_sat   = r_out_sat;
    assign io_bus.out_mode  = (r_out_mode == MODE_MULT);
    assign io_bus.out_real  = r_out_re;
    assign io_bus.out_imag  = r_out_im;

endmodule

// File: tb/tb_sdf_twiddle_multiplier.sv
// -----------------------------------------------------------------------------
// tb_sdf_twiddle_multiplier
// Three instances share clock, reset and input stimulus:
//   A: STAGE=1, OUT_W=16 (M=4)    B: STAGE=0, OUT_W=16 (M=8)
//   C: STAGE=0, OUT_W=15 (M=8)
// Inputs change on the falling edge; outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_sdf_twiddle_multiplier;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              tb_valid;
    logic              tb_sop;
    logic signed [14:0] tb_re;
    logic signed [14:0] tb_im;

    sdf_twiddle_multiplier_if #(.DATA_W(15), .OUT_W(16)) ifa ();
    sdf_twiddle_multiplier_if #(.DATA_W(15), .OUT_W(16)) ifb ();
    sdf_twiddle_multiplier_if #(.DATA_W(15), .OUT_W(15)) ifc ();

    assign ifa.in_valid = tb_valid;
    assign ifa.in_sop   = tb_sop;
    assign ifa.in_real  = tb_re;
    assign ifa.in_imag  = tb_im;
    assign ifb.in_valid = tb_valid;
    assign ifb.in_sop   = tb_sop;
    assign ifb.in_real  = tb_re;
    assign ifb.in_imag  = tb_im;
    assign ifc.in_valid = tb_valid;
    assign ifc.in_sop   = tb_sop;
    assign ifc.in_real  = tb_re;
    assign ifc.in_imag  = tb_im;

    sdf_twiddle_multiplier #(.N_LOG2(3), .STAGE(1), .DATA_W(15), .TW_W(13), .TW_FRAC(11), .OUT_W(16))
        u_dut_a (.clk(clk), .rst_n(rst_n), .io_bus(ifa));
    sdf_twiddle_multiplier #(.N_LOG2(3), .STAGE(0), .DATA_W(15), .TW_W(13), .TW_FRAC(11), .OUT_W(16))
        u_dut_b (.clk(clk), .rst_n(rst_n), .io_bus(ifb));
    sdf_twiddle_multiplier #(.N_LOG2(3), .STAGE(0), .DATA_W(15), .TW_W(13), .TW_FRAC(11), .OUT_W(15))
        u_dut_c (.clk(clk), .rst_n(rst_n), .io_bus(ifc));

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit v;     bit s;     int re;   int im;
        bit ev;    bit esop;  bit emode; int ere; int eim; bit esat;
    } step_t;

    step_t seq[$];

    function automatic step_t mk(bit v, bit s, int re, int im,
                                 bit ev, bit esop, bit emode, int ere, int eim, bit esat);
        step_t r;
        r.v = v;   r.s = s;       r.re = re;      r.im = im;
        r.ev = ev; r.esop = esop; r.emode = emode; r.ere = ere; r.eim = eim; r.esat = esat;
        return r;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one input cycle, return on the next falling edge.
    task automatic drive(input bit v, input bit s, input int re, input int im);
        tb_valid = v;
        tb_sop   = s;
        tb_re    = 15'(re);
        tb_im    = 15'(im);
        @(negedge clk);
    endtask

    task automatic chk_a(input string tag, input step_t r);
        chk({tag, ".valid"}, 64'(ifa.out_valid), 64'(r.ev));
        chk({tag, ".sop"},   64'(ifa.out_sop),   64'(r.esop));
        chk({tag, ".mode"},  64'(ifa.out_mode),  64'(r.emode));
        chk({tag, ".re"},    64'(ifa.out_real),  64'(r.ere));
        chk({tag, ".im"},    64'(ifa.out_imag),  64'(r.eim));
        chk({tag, ".sat"},   64'(ifa.out_sat),   64'(r.esat));
        $display("%s: valid=%0d sop=%0d mode=%0d re=%0d im=%0d sat=%0d", tag,
                 ifa.out_valid, ifa.out_sop, ifa.out_mode, ifa.out_real, ifa.out_imag, ifa.out_sat);
    endtask

    // Row i's expectation is what the output shows after row i+2 is applied.
    task automatic run_seq(input string name);
        for (int i = 0; i < seq.size() + 2; i++) begin
            if (i < seq.size())
                drive(seq[i].v, seq[i].s, seq[i].re, seq[i].im);
            else
                drive(1'b0, 1'b0, 0, 0);
            if (i >= 2)
                chk_a($sformatf("%s[%0d]", name, i - 2), seq[i - 2]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        tb_valid = 1'b0;
        tb_sop   = 1'b0;
        tb_re    = '0;
        tb_im    = '0;
        repeat (2) @(negedge clk);

        // Reset state on all three instances.
        chk("rst.a.valid", 64'(ifa.out_valid), 64'(0));
        chk("rst.a.sop",   64'(ifa.out_sop),   64'(0));
        chk("rst.a.mode",  64'(ifa.out_mode),  64'(0));
        chk("rst.a.re",    64'(ifa.out_real),  64'(0));
        chk("rst.a.im",    64'(ifa.out_imag),  64'(0));
        chk("rst.a.sat",   64'(ifa.out_sat),   64'(0));
        chk("rst.b.valid", 64'(ifb.out_valid), 64'(0));
        chk("rst.b.re",    64'(ifb.out_real),  64'(0));
        chk("rst.b.im",    64'(ifb.out_imag),  64'(0));
        chk("rst.c.valid", 64'(ifc.out_valid), 64'(0));
        chk("rst.c.re",    64'(ifc.out_real),  64'(0));
        chk("rst.c.sat",   64'(ifc.out_sat),   64'(0));
        rst_n = 1'b1;

        // Full frame on A (M=4): p=0 -> W=1, p=1 -> W=-j, p=2,3 bypass.
        // 8192 * -j -> (0, -8192) after rounding.
        seq = '{};
        seq.push_back(mk(1, 1, 8192, 0, 1, 1, 1, 8192,     0, 0));
        seq.push_back(mk(1, 0, 8192, 0, 1, 0, 1,    0, -8192, 0));
        seq.push_back(mk(1, 0, 8192, 0, 1, 0, 0, 8192,     0, 0));
        seq.push_back(mk(1, 0, 8192, 0, 1, 0, 0, 8192,     0, 0));
        seq.push_back(mk(1, 0, 8192, 0, 1, 0, 1, 8192,     0, 0));
        seq.push_back(mk(1, 0, 8192, 0, 1, 0, 1,    0, -8192, 0));
        seq.push_back(mk(1, 0, 8192, 0, 1, 0, 0, 8192,     0, 0));
        seq.push_back(mk(1, 0, 8192, 0, 1, 0, 0, 8192,     0, 0));
        run_seq("frame");

        // Gaps: valid 1,0,0,1,1,0,1; idle rows expect held data, sop/sat 0.
        seq = '{};
        seq.push_back(mk(1, 1, 8192, 0, 1, 1, 1, 8192,     0, 0));
        seq.push_back(mk(0, 0,    0, 0, 0, 0, 1, 8192,     0, 0));
        seq.push_back(mk(0, 1,    0, 0, 0, 0, 1, 8192,     0, 0));
        seq.push_back(mk(1, 0, 8192, 0, 1, 0, 1,    0, -8192, 0));
        seq.push_back(mk(1, 0, 8192, 0, 1, 0, 0, 8192,     0, 0));
        seq.push_back(mk(0, 0,    0, 0, 0, 0, 0, 8192,     0, 0));
        seq.push_back(mk(1, 0, 8192, 0, 1, 0, 0, 8192,     0, 0));
        run_seq("gaps");

        // Resync: sop at cnt=5 forces p=0; the sample after it is cnt=1 (p=1).
        seq = '{};
        seq.push_back(mk(1, 1, 8192, 0, 1, 1, 1, 8192,     0, 0));
        seq.push_back(mk(1, 0, 8192, 0, 1, 0, 1,    0, -8192, 0));
        seq.push_back(mk(1, 0, 8192, 0, 1, 0, 0, 8192,     0, 0));
        seq.push_back(mk(1, 0, 8192, 0, 1, 0, 0, 8192,     0, 0));
        seq.push_back(mk(1, 0, 8192, 0, 1, 0, 1, 8192,     0, 0));
        seq.push_back(mk(1, 1, 8192, 0, 1, 1, 1, 8192,     0, 0));
        seq.push_back(mk(1, 0, 8192, 0, 1, 0, 1,    0, -8192, 0));
        run_seq("resync");

        // STAGE=0, p=1, W=(1448,-1448): (16383,0) -> (11583,-11583).
        // On A (p=1, W=-j) the same sample gives (0,-16383).
        drive(1'b1, 1'b1, 0, 0);
        drive(1'b1, 1'b0, 16383, 0);
        drive(1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 0, 0);
        chk("w8.b.valid", 64'(ifb.out_valid), 64'(1));
        chk("w8.b.mode",  64'(ifb.out_mode),  64'(1));
        chk("w8.b.re",    64'(ifb.out_real),  64'(11583));
        chk("w8.b.im",    64'(ifb.out_imag),  64'(-11583));
        chk("w8.b.sat",   64'(ifb.out_sat),   64'(0));
        chk("w8.c.re",    64'(ifc.out_real),  64'(11583));
        chk("w8.a.re",    64'(ifa.out_real),  64'(0));
        chk("w8.a.im",    64'(ifa.out_imag),  64'(-16383));
        $display("w8: b=(%0d,%0d) a=(%0d,%0d)", ifb.out_real, ifb.out_imag, ifa.out_real, ifa.out_imag);

        // Saturation: (-16384,-16384) at p=1 -> R=-23168, I=0.
        // C (15-bit out) clamps to -16384 and flags sat; B fits.
        drive(1'b1, 1'b1, 0, 0);
        drive(1'b1, 1'b0, -16384, -16384);
        drive(1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 0, 0);
        chk("sat.c.valid", 64'(ifc.out_valid), 64'(1));
        chk("sat.c.re",    64'(ifc.out_real),  64'(-16384));
        chk("sat.c.im",    64'(ifc.out_imag),  64'(0));
        chk("sat.c.sat",   64'(ifc.out_sat),   64'(1));
        chk("sat.b.re",    64'(ifb.out_real),  64'(-23168));
        chk("sat.b.sat",   64'(ifb.out_sat),   64'(0));
        $display("sat: c=(%0d,%0d) sat=%0d b=(%0d,%0d)", ifc.out_real, ifc.out_imag, ifc.out_sat,
                 ifb.out_real, ifb.out_imag);
        drive(1'b0, 1'b0, 0, 0);
        chk("sat.gap.valid", 64'(ifc.out_valid), 64'(0));
        chk("sat.gap.sat",   64'(ifc.out_sat),   64'(0));
        chk("sat.gap.re",    64'(ifc.out_real),  64'(-16384));
        $display("sat.gap: valid=%0d sat=%0d re=%0d", ifc.out_valid, ifc.out_sat, ifc.out_real);

        // Reset with two samples in flight (counter left at 2).
        tb_re = 15'sd8192;
        tb_im = 15'sd0;
        drive(1'b1, 1'b1, 8192, 0);
        drive(1'b1, 1'b0, 8192, 0);
        tb_valid = 1'b0;
        tb_sop   = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("mrst.valid", 64'(ifa.out_valid), 64'(0));
        chk("mrst.sop",   64'(ifa.out_sop),   64'(0));
        chk("mrst.mode",  64'(ifa.out_mode),  64'(0));
        chk("mrst.re",    64'(ifa.out_real),  64'(0));
        chk("mrst.im",    64'(ifa.out_imag),  64'(0));
        chk("mrst.sat",   64'(ifa.out_sat),   64'(0));
        $display("mrst: valid=%0d re=%0d im=%0d", ifa.out_valid, ifa.out_real, ifa.out_imag);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 0, 0);
            chk($sformatf("mrst.flush[%0d].valid", i), 64'(ifa.out_valid), 64'(0));
            $display("mrst.flush[%0d]: valid=%0d", i, ifa.out_valid);
        end

        // Counter restarted at 0: first plain sample is p=0, next p=1; then sop.
        seq = '{};
        seq.push_back(mk(1, 0, 8192, 0, 1, 0, 1, 8192,     0, 0));
        seq.push_back(mk(1, 0, 8192, 0, 1, 0, 1,    0, -8192, 0));
        seq.push_back(mk(1, 1, 8192, 0, 1, 1, 1, 8192,     0, 0));
        run_seq("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
